alu_muldiv_ctrl: RTL and testbench
==================================

# alu_muldiv_ctrl

Parametrised successor to the EX-stage ALU control decoder. It produces the same 4-bit ALU operation code from ALUOp/funct and adds a multi-cycle multiply/divide engine with HI/LO registers for MULT/MULTU/DIV/DIVU/MFHI/MFLO/MTHI/MTLO. It sits in the EX stage beside the ALU and drives a stall request back to the hazard unit while an iterative operation is in flight.

## Interface
- WIDTH, 32: operand and HI/LO width; must be ≥ 4 and even.
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  synchronous, active-low reset.
- valid  in  1  the EX-stage instruction is real (not a bubble).
- flush  in  1  kills the EX instruction and aborts any running mul/div.
- ALUOp  in  4  op class from main control.
- funct  in  6  instruction funct field.
- src_a  in  WIDTH  rs operand (dividend / multiplicand).
- src_b  in  WIDTH  rt operand (divisor / multiplier).
- alu_ctrl_out  out  4  ALU operation code (combinational).
- hilo_rdata  out  WIDTH  HI for MFHI, LO for MFLO, otherwise 0 (combinational from registers).
- hilo_re  out  1  the current instruction is MFHI/MFLO and is not stalled.
- stall  out  1  hold IF/ID/EX this cycle.
- busy  out  1  engine is not IDLE.
- done  out  1  one-cycle pulse: HI/LO just updated by mul/div.
- hi, lo  out  WIDTH each  architectural HI/LO registers.

## Operation
- ALUOp decode: 0000→0010 (add), 0001→0110 (sub), 0011→0101 (lui), 0101→0000 (and), 0100→0001 (or), 0110→0011 (xor), 1010→1010 (nor), 1000→0111 (slt); 0010 uses funct. Any other ALUOp → 0010.
- funct decode with ALUOp=0010: 100000/100001→0010, 100010/100011→0110, 100100→0000, 100101→0001, 100110→0011, 100111→1010, 101010/101011→0111, 000000→1000, 000010→0100, 000011→1100. Mul/div/HI/LO functs and any unlisted funct → 0010.
- Mul/div functs: 011000 MULT, 011001 MULTU, 011010 DIV, 011011 DIVU, 010000 MFHI, 010001 MTHI, 010010 MFLO, 010011 MTLO. They take effect only when ALUOp=0010, valid=1, flush=0.
- FSM states: IDLE, RUN, FIN.
  - IDLE→RUN on an accepted mul/div. Latch operands; signed ops use magnitudes and latch the result sign(s); load counter=WIDTH.
  - RUN performs one shift-add (mul) or one restoring subtract (div) step per cycle and decrements the counter. RUN→FIN when counter reaches 1.
  - FIN applies sign correction, writes HI/LO, then goes →IDLE with done=1 in the following cycle.
  - DIV/DIVU with src_b=0 goes IDLE→FIN directly and writes LO={WIDTH{1}}, HI=src_a.
- Results: mul gives {HI,LO} = 2·WIDTH-bit product. Div gives LO = quotient truncated toward zero and HI = remainder with the dividend's sign. Signed most-negative/−1 gives LO = most-negative, HI = 0.
- MTHI/MTLO write src_a into HI/LO at the edge when accepted in IDLE.
- stall = busy & valid & (ALUOp=0010) & funct ∈ {mul/div, MFHI, MFLO, MTHI, MTLO}. A stalled instruction is re-presented and is not accepted until IDLE.
- flush: while busy, the FSM goes to IDLE at the next edge. HI/LO are left unchanged and done stays 0. An instruction presented with flush=1 is never accepted.
- A flush in FIN discards the write.

## Timing
- Reset (rst_n=0 at an edge): state IDLE, hi=lo=0, done=0, busy=0, stall=0. Reset mid-operation discards the operation.
- alu_ctrl_out, hilo_rdata, stall and hilo_re are combinational. busy and done are registered.
- Mul/div accepted at edge E0: busy=1 for cycles 1..WIDTH+1 (RUN WIDTH cycles, FIN 1 cycle). HI/LO are updated at the end of cycle WIDTH+1. done=1 and new HI/LO are visible in cycle WIDTH+2.
- Divide-by-zero: busy in cycle 1 only; done and HI/LO are visible in cycle 2.
- A new mul/div may be accepted in the done cycle. A back-to-back issue sees stall=0 in that cycle.
- MFHI/MFLO in the done cycle return the new values.

## Test plan
- Decoder sweep: every ALUOp and every listed funct → the codes above. ALUOp=0010, funct=111111 → 0010.
- MULT src_a=0xFFFFFFFD (−3), src_b=5 → cycle 34: done=1, HI=0xFFFFFFFF, LO=0xFFFFFFF1. busy is high in cycles 1–33. MULTU of the same operands → HI=0x00000004, LO=0xFFFFFFF1.
- DIV −7/2 → LO=0xFFFFFFFD, HI=0xFFFFFFFF. DIVU 7/0 → done in cycle 2, LO=0xFFFFFFFF, HI=0x7. DIV 0x80000000/0xFFFFFFFF → LO=0x80000000, HI=0.
- MFLO issued in cycle 5 of a MULT: stall=1 through cycle 33, hilo_re=0. In cycle 34, stall=0, hilo_re=1, hilo_rdata = new LO.
- flush in cycle 10 of a DIV: busy=0 from cycle 11, done never pulses, HI/LO keep their prior values. A second flush arriving with a new MULT in the same cycle is not accepted.
- rst_n=0 in cycle 20 of a MULT: next cycle hi=lo=0, busy=0, done=0. MTHI 0x1234 afterwards → hi=0x1234 the following cycle.

Source files
------------

// File: rtl/alu_muldiv_ctrl.sv
// EX-stage ALU control decoder with an iterative multiply/divide engine and
// the architectural HI/LO registers. While a mul/div is in flight, any
// instruction that touches HI/LO or the engine is held via stall.
module alu_muldiv_ctrl #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             valid,
    input  logic             flush,
    input  logic [3:0]       ALUOp,
    input  logic [5:0]       funct,
    input  logic [WIDTH-1:0] src_a,
    input  logic [WIDTH-1:0] src_b,
    output logic [3:0]       alu_ctrl_out,
    output logic [WIDTH-1:0] hilo_rdata,
    output logic             hilo_re,
    output logic             stall,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CNT_W = $clog2(WIDTH + 1);

    localparam logic [5:0] F_MFHI  = 6'b010000;
    localparam logic [5:0] F_MTHI  = 6'b010001;
    localparam logic [5:0] F_MFLO  = 6'b010010;
    localparam logic [5:0] F_MTLO  = 6'b010011;
    localparam logic [5:0] F_MULT  = 6'b011000;
    localparam logic [5:0] F_MULTU = 6'b011001;
    localparam logic [5:0] F_DIV   = 6'b011010;
    localparam logic [5:0] F_DIVU  = 6'b011011;

    typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;

    // Two's-complement negation of a WIDTH-bit value.
    function automatic logic [WIDTH-1:0] neg_w(input logic [WIDTH-1:0] v);
        return ~v + WIDTH'(1);
    endfunction

    // Two's-complement negation of a double-width product.
    function automatic logic [2*WIDTH-1:0] neg_2w(input logic [2*WIDTH-1:0] v);
        return ~v + (2*WIDTH)'(1);
    endfunction

    // Magnitude of an operand; only signed ops take the absolute value.
    function automatic logic [WIDTH-1:0] mag(input logic signed [WIDTH-1:0] v,
                                             input logic is_signed);
        return (is_signed && v < 0) ? neg_w(v) : v;
    endfunction

    // Control state
    state_t             state_q, state_d;
    logic               done_q, done_d;
    logic [WIDTH-1:0]   hi_q, hi_d;
    logic [WIDTH-1:0]   lo_q, lo_d;

    // Datapath state (loaded on accept, no reset needed)
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [2*WIDTH-1:0] prod_q, prod_d;
    logic [WIDTH-1:0]   opnd_q, opnd_d;
    logic               is_div_q, is_div_d;
    logic               divz_q, divz_d;
    logic               res_neg_q, res_neg_d;
    logic               rem_neg_q, rem_neg_d;

    // Instruction classification
    logic is_r, is_mfhi, is_mflo, is_mthi, is_mtlo, is_muldiv, is_hl_op;
    logic op_ok, sgn_op;
    logic signed [WIDTH-1:0] a_s, b_s;
    logic [WIDTH-1:0] a_mag, b_mag;

    assign is_r      = (ALUOp == 4'b0010);
    assign is_mfhi   = (funct == F_MFHI);
    assign is_mflo   = (funct == F_MFLO);
    assign is_mthi   = (funct == F_MTHI);
    assign is_mtlo   = (funct == F_MTLO);
    assign is_muldiv = (funct == F_MULT) || (funct == F_MULTU) ||
                       (funct == F_DIV)  || (funct == F_DIVU);
    assign is_hl_op  = is_muldiv | is_mfhi | is_mflo | is_mthi | is_mtlo;

    assign busy    = (state_q != IDLE);
    assign stall   = busy & valid & is_r & is_hl_op;
    assign op_ok   = valid & ~flush & is_r & ~busy;
    assign hilo_re = valid & is_r & (is_mfhi | is_mflo) & ~stall;

    assign hilo_rdata = (is_r && is_mfhi) ? hi_q :
                        (is_r && is_mflo) ? lo_q : '0;

    assign done = done_q;
    assign hi   = hi_q;
    assign lo   = lo_q;

    // funct[0] clear selects the signed variant (MULT/DIV)
    assign sgn_op = ~funct[0];
    assign a_s    = src_a;
    assign b_s    = src_b;
    assign a_mag  = mag(a_s, sgn_op);
    assign b_mag  = mag(b_s, sgn_op);

    // One shift-add multiply step: conditionally add multiplicand into the
    // upper half, then shift the whole product right.
    logic [WIDTH:0]     mul_sum;
    logic [2*WIDTH-1:0] mul_next;
    assign mul_sum  = prod_q[0] ? ({1'b0, prod_q[2*WIDTH-1:WIDTH]} + {1'b0, opnd_q})
                                :  {1'b0, prod_q[2*WIDTH-1:WIDTH]};
    assign mul_next = {mul_sum, prod_q[WIDTH-1:1]};

    // One restoring divide step: upper half is the partial remainder, lower
    // half shifts the dividend out and the quotient bits in.
    logic [WIDTH:0]     div_shift, div_diff;
    logic               div_bit;
    logic [WIDTH-1:0]   div_rem;
    logic [2*WIDTH-1:0] div_next;
    assign div_shift = {prod_q[2*WIDTH-1:WIDTH], prod_q[WIDTH-1]};
    assign div_diff  = div_shift - {1'b0, opnd_q};
    assign div_bit   = ~div_diff[WIDTH];
    assign div_rem   = div_bit ? div_diff[WIDTH-1:0] : div_shift[WIDTH-1:0];
    assign div_next  = {div_rem, prod_q[WIDTH-2:0], div_bit};

    // Sign-corrected results written in FIN
    logic [2*WIDTH-1:0] mul_res;
    logic [WIDTH-1:0]   quo_res, rem_res;
    assign mul_res = res_neg_q ? neg_2w(prod_q) : prod_q;
    assign quo_res = res_neg_q ? neg_w(prod_q[WIDTH-1:0]) : prod_q[WIDTH-1:0];
    assign rem_res = rem_neg_q ? neg_w(prod_q[2*WIDTH-1:WIDTH]) : prod_q[2*WIDTH-1:WIDTH];

    // ALU operation code from op class and funct
    always_comb begin
        alu_ctrl_out = 4'b0010;
        case (ALUOp)
            4'b0000: alu_ctrl_out = 4'b0010;
            4'b0001: alu_ctrl_out = 4'b0110;
            4'b0011: alu_ctrl_out = 4'b0101;
            4'b0101: alu_ctrl_out = 4'b0000;
            4'b0100: alu_ctrl_out = 4'b0001;
            4'b0110: alu_ctrl_out = 4'b0011;
            4'b1010: alu_ctrl_out = 4'b1010;
            4'b1000: alu_ctrl_out = 4'b0111;
            4'b0010: begin
                case (funct)
                    6'b100000, 6'b100001: alu_ctrl_out = 4'b0010;
                    6'b100010, 6'b100011: alu_ctrl_out = 4'b0110;
                    6'b100100:            alu_ctrl_out = 4'b0000;
                    6'b100101:            alu_ctrl_out = 4'b0001;
                    6'b100110:            alu_ctrl_out = 4'b0011;
                    6'b100111:            alu_ctrl_out = 4'b1010;
                    6'b101010, 6'b101011: alu_ctrl_out = 4'b0111;
                    6'b000000:            alu_ctrl_out = 4'b1000;
                    6'b000010:            alu_ctrl_out = 4'b0100;
                    6'b000011:            alu_ctrl_out = 4'b1100;
                    default:              alu_ctrl_out = 4'b0010;
                endcase
            end
            default: alu_ctrl_out = 4'b0010;
        endcase
    end

    // Next-state logic for the mul/div FSM, datapath and HI/LO
    always_comb begin
        state_d   = state_q;
        done_d    = 1'b0;
        hi_d      = hi_q;
        lo_d      = lo_q;
        cnt_d     = cnt_q;
        prod_d    = prod_q;
        opnd_d    = opnd_q;
        is_div_d  = is_div_q;
        divz_d    = divz_q;
        res_neg_d = res_neg_q;
        rem_neg_d = rem_neg_q;
        case (state_q)
            IDLE: begin
                if (op_ok) begin
                    if (is_mthi) hi_d = src_a;
                    if (is_mtlo) lo_d = src_a;
                    if (is_muldiv) begin
                        is_div_d  = funct[1];
                        res_neg_d = sgn_op & (src_a[WIDTH-1] ^ src_b[WIDTH-1]);
                        rem_neg_d = sgn_op & src_a[WIDTH-1];
                        cnt_d     = CNT_W'(WIDTH);
                        if (funct[1] && src_b == '0) begin
                            divz_d  = 1'b1;
                            prod_d  = {src_a, {WIDTH{1'b1}}};
                            state_d = FIN;
                        end else begin
                            divz_d  = 1'b0;
                            opnd_d  = funct[1] ? b_mag : a_mag;
                            prod_d  = {{WIDTH{1'b0}}, (funct[1] ? a_mag : b_mag)};
                            state_d = RUN;
                        end
                    end
                end
            end
            RUN: begin
                if (flush) begin
                    state_d = IDLE;
                end else begin
                    prod_d = is_div_q ? div_next : mul_next;
                    cnt_d  = cnt_q - CNT_W'(1);
                    if (cnt_q == CNT_W'(1)) state_d = FIN;
                end
            end
            FIN: begin
                state_d = IDLE;
                if (!flush) begin
                    done_d = 1'b1;
                    if (divz_q) begin
                        hi_d = prod_q[2*WIDTH-1:WIDTH];
                        lo_d = prod_q[WIDTH-1:0];
                    end else if (is_div_q) begin
                        hi_d = rem_res;
                        lo_d = quo_res;
                    end else begin
                        hi_d = mul_res[2*WIDTH-1:WIDTH];
                        lo_d = mul_res[WIDTH-1:0];
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Control and architectural registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            done_q  <= 1'b0;
            hi_q    <= '0;
            lo_q    <= '0;
        end else begin
            state_q <= state_d;
            done_q  <= done_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
        end
    end

    // Iteration datapath registers
    always_ff @(posedge clk) begin
        cnt_q     <= cnt_d;
        prod_q    <= prod_d;
        opnd_q    <= opnd_d;
        is_div_q  <= is_div_d;
        divz_q    <= divz_d;
        res_neg_q <= res_neg_d;
        rem_neg_q <= rem_neg_d;
    end

endmodule

// File: tb/tb_alu_muldiv_ctrl.sv
// Self-checking bench for alu_muldiv_ctrl: decoder sweep, mul/div results via
// a scoreboard, stall/flush/reset timing.
module tb_alu_muldiv_ctrl;

    localparam int W = 32;

    localparam logic [5:0] F_MFHI  = 6'h10;
    localparam logic [5:0] F_MTHI  = 6'h11;
    localparam logic [5:0] F_MFLO  = 6'h12;
    localparam logic [5:0] F_MTLO  = 6'h13;
    localparam logic [5:0] F_MULT  = 6'h18;
    localparam logic [5:0] F_MULTU = 6'h19;
    localparam logic [5:0] F_DIV   = 6'h1A;
    localparam logic [5:0] F_DIVU  = 6'h1B;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         valid;
    logic         flush;
    logic [3:0]   ALUOp;
    logic [5:0]   funct;
    logic [W-1:0] src_a, src_b;
    logic [3:0]   alu_ctrl_out;
    logic [W-1:0] hilo_rdata;
    logic         hilo_re, stall, busy, done;
    logic [W-1:0] hi, lo;

    int total = 0;
    int bad   = 0;
    logic [63:0] sb_q[$];

    // ALUOp sweep expectations with funct=111111
    localparam logic [3:0] ATBL [16] = '{
        4'h2, 4'h6, 4'h2, 4'h5, 4'h1, 4'h0, 4'h3, 4'h2,
        4'h7, 4'h2, 4'hA, 4'h2, 4'h2, 4'h2, 4'h2, 4'h2
    };
    // {funct, code} pairs with ALUOp=0010
    localparam logic [9:0] FTBL [22] = '{
        {6'h20, 4'h2}, {6'h21, 4'h2}, {6'h22, 4'h6}, {6'h23, 4'h6},
        {6'h24, 4'h0}, {6'h25, 4'h1}, {6'h26, 4'h3}, {6'h27, 4'hA},
        {6'h2A, 4'h7}, {6'h2B, 4'h7}, {6'h00, 4'h8}, {6'h02, 4'h4},
        {6'h03, 4'hC}, {6'h18, 4'h2}, {6'h19, 4'h2}, {6'h1A, 4'h2},
        {6'h1B, 4'h2}, {6'h10, 4'h2}, {6'h11, 4'h2}, {6'h12, 4'h2},
        {6'h13, 4'h2}, {6'h3F, 4'h2}
    };

    alu_muldiv_ctrl #(.WIDTH(W)) dut (
        .clk(clk), .rst_n(rst_n), .valid(valid), .flush(flush),
        .ALUOp(ALUOp), .funct(funct), .src_a(src_a), .src_b(src_b),
        .alu_ctrl_out(alu_ctrl_out), .hilo_rdata(hilo_rdata),
        .hilo_re(hilo_re), .stall(stall), .busy(busy), .done(done),
        .hi(hi), .lo(lo)
    );

    always #5 clk = ~clk;

    // Reference {HI,LO} for a mul/div, using 64-bit arithmetic
    function automatic logic [63:0] model(input logic [5:0] f,
                                          input logic [31:0] a, input logic [31:0] b);
        longint sa, sb, q, r;
        logic [63:0] p;
        p = '0;
        case (f)
            F_MULT: begin
                sa = $signed(a); sb = $signed(b);
                q = sa * sb;
                p = q;
            end
            F_MULTU: p = {32'b0, a} * {32'b0, b};
            F_DIV: begin
                if (b == 0) p = {a, 32'hFFFFFFFF};
                else begin
                    sa = $signed(a); sb = $signed(b);
                    q = sa / sb; r = sa % sb;
                    p = {r[31:0], q[31:0]};
                end
            end
            F_DIVU: begin
                if (b == 0) p = {a, 32'hFFFFFFFF};
                else p = {a % b, a / b};
            end
            default: p = '0;
        endcase
        return p;
    endfunction

    // Scoreboard: every done pulse must match the oldest outstanding op
    always @(negedge clk) begin
        if (rst_n && done === 1'b1) begin
            total++;
            if (sb_q.size() == 0) begin
                bad++;
                $display("FAIL sb_unexpected_done actual hi=%h lo=%h required=no done", hi, lo);
            end else begin
                logic [63:0] e;
                e = sb_q.pop_front();
                if ({hi, lo} !== e) begin
                    bad++;
                    $display("FAIL sb_hilo actual=%h required=%h", {hi, lo}, e);
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b);
        valid = 1'b1; ALUOp = 4'b0010; funct = f; src_a = a; src_b = b;
        sb_q.push_back(model(f, a, b));
        tick();
        valid = 1'b0; ALUOp = 4'b0000; funct = 6'h00;
    endtask

    task automatic mt(input logic [5:0] f, input logic [31:0] v);
        valid = 1'b1; ALUOp = 4'b0010; funct = f; src_a = v;
        tick();
        valid = 1'b0; ALUOp = 4'b0000; funct = 6'h00;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; flush = 1'b0;
        valid = 1'b1; ALUOp = 4'b0010; funct = F_MULT; src_a = 32'h5; src_b = 32'h3;
        tick(); tick();
        #1;
        total++; if (hi !== '0)    begin bad++; $display("FAIL reset_hi actual=%h required=0", hi); end
        total++; if (lo !== '0)    begin bad++; $display("FAIL reset_lo actual=%h required=0", lo); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy actual=%b required=0", busy); end
        total++; if (done !== 1'b0) begin bad++; $display("FAIL reset_done actual=%b required=0", done); end
        total++; if (stall !== 1'b0) begin bad++; $display("FAIL reset_stall actual=%b required=0", stall); end
        valid = 1'b0; ALUOp = 4'b0000; funct = 6'h00;
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_decoder();
        logic [9:0] e;
        valid = 1'b0;
        for (int i = 0; i < 16; i++) begin
            ALUOp = 4'(i); funct = 6'h3F;
            #1;
            total++;
            if (alu_ctrl_out !== ATBL[i]) begin
                bad++;
                $display("FAIL dec_aluop op=%h actual=%h required=%h", i, alu_ctrl_out, ATBL[i]);
            end
        end
        for (int i = 0; i < 22; i++) begin
            e = FTBL[i];
            ALUOp = 4'b0010; funct = e[9:4];
            #1;
            total++;
            if (alu_ctrl_out !== e[3:0]) begin
                bad++;
                $display("FAIL dec_funct funct=%h actual=%h required=%h", e[9:4], alu_ctrl_out, e[3:0]);
            end
        end
        ALUOp = 4'b0000; funct = 6'h00;
        tick();
    endtask

    task automatic test_mul();
        int nb, nd;
        nb = 0; nd = 0;
        issue(F_MULT, 32'hFFFFFFFD, 32'h5);
        for (int k = 1; k <= 33; k++) begin
            #1;
            if (busy !== 1'b1) nb++;
            if (done !== 1'b0) nd++;
            tick();
        end
        #1;
        total++; if (nb != 0) begin bad++; $display("FAIL mul_busy_window actual=%0d idle cycles required=0", nb); end
        total++; if (nd != 0) begin bad++; $display("FAIL mul_done_early actual=%0d pulses required=0", nd); end
        total++; if (done !== 1'b1) begin bad++; $display("FAIL mul_done34 actual=%b required=1", done); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL mul_busy34 actual=%b required=0", busy); end
        total++; if (hi !== 32'hFFFFFFFF) begin bad++; $display("FAIL mult_hi actual=%h required=ffffffff", hi); end
        total++; if (lo !== 32'hFFFFFFF1) begin bad++; $display("FAIL mult_lo actual=%h required=fffffff1", lo); end
        tick();
    endtask

    task automatic test_back_to_back();
        issue(F_MULT, 32'hFFFFFFFD, 32'h5);
        for (int k = 1; k <= 33; k++) tick();
        valid = 1'b1; ALUOp = 4'b0010; funct = F_MULTU; src_a = 32'hFFFFFFFD; src_b = 32'h5;
        #1;
        total++; if (stall !== 1'b0) begin bad++; $display("FAIL b2b_stall actual=%b required=0", stall); end
        total++; if (done !== 1'b1) begin bad++; $display("FAIL b2b_done actual=%b required=1", done); end
        sb_q.push_back(model(F_MULTU, 32'hFFFFFFFD, 32'h5));
        tick();
        valid = 1'b0; ALUOp = 4'b0000; funct = 6'h00;
        #1;
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL b2b_busy actual=%b required=1", busy); end
        for (int k = 1; k <= 33; k++) tick();
        #1;
        total++; if (done !== 1'b1) begin bad++; $display("FAIL multu_done actual=%b required=1", done); end
        total++; if (hi !== 32'h00000004) begin bad++; $display("FAIL multu_hi actual=%h required=00000004", hi); end
        total++; if (lo !== 32'hFFFFFFF1) begin bad++; $display("FAIL multu_lo actual=%h required=fffffff1", lo); end
        tick();
    endtask

    task automatic test_div();
        logic [5:0] f;
        logic [31:0] a, b;
        int c;
        issue(F_DIV, 32'hFFFFFFF9, 32'h2);
        for (int k = 1; k <= 33; k++) tick();
        #1;
        total++; if (done !== 1'b1) begin bad++; $display("FAIL div_done actual=%b required=1", done); end
        total++; if (lo !== 32'hFFFFFFFD) begin bad++; $display("FAIL div_lo actual=%h required=fffffffd", lo); end
        total++; if (hi !== 32'hFFFFFFFF) begin bad++; $display("FAIL div_hi actual=%h required=ffffffff", hi); end
        issue(F_DIVU, 32'h7, 32'h0);
        #1;
        total++; if (busy !== 1'b1 || done !== 1'b0) begin bad++; $display("FAIL divz_c1 actual busy=%b done=%b required busy=1 done=0", busy, done); end
        tick();
        #1;
        total++; if (done !== 1'b1 || busy !== 1'b0) begin bad++; $display("FAIL divz_c2 actual done=%b busy=%b required done=1 busy=0", done, busy); end
        total++; if (lo !== 32'hFFFFFFFF) begin bad++; $display("FAIL divz_lo actual=%h required=ffffffff", lo); end
        total++; if (hi !== 32'h7) begin bad++; $display("FAIL divz_hi actual=%h required=00000007", hi); end
        issue(F_DIV, 32'h80000000, 32'hFFFFFFFF);
        for (int k = 1; k <= 33; k++) tick();
        #1;
        total++; if (lo !== 32'h80000000) begin bad++; $display("FAIL divovf_lo actual=%h required=80000000", lo); end
        total++; if (hi !== 32'h0) begin bad++; $display("FAIL divovf_hi actual=%h required=00000000", hi); end
        tick();
        for (int n = 0; n < 12; n++) begin
            f = 6'h18 + 6'($urandom_range(0, 3));
            a = $urandom();
            b = (n % 4 == 3) ? 32'h0 : ((n % 2 == 0) ? 32'($urandom_range(1, 1000)) : $urandom());
            if (n % 3 == 0) a = -a;
            issue(f, a, b);
            c = 0;
            while (c < 40 && done !== 1'b1) begin
                tick();
                c++;
            end
            total++;
            if (done !== 1'b1) begin bad++; $display("FAIL rand_timeout funct=%h actual=no done required=done", f); end
            tick();
        end
    endtask

    task automatic test_mflo_stall();
        logic [63:0] e;
        int n;
        n = 0;
        e = model(F_MULT, 32'h12345678, 32'h9ABCDEF0);
        issue(F_MULT, 32'h12345678, 32'h9ABCDEF0);
        for (int k = 1; k <= 4; k++) tick();
        valid = 1'b1; ALUOp = 4'b0010; funct = F_MFLO;
        for (int k = 5; k <= 33; k++) begin
            #1;
            if (stall !== 1'b1 || hilo_re !== 1'b0) n++;
            tick();
        end
        #1;
        total++; if (n != 0) begin bad++; $display("FAIL mflo_held actual=%0d bad cycles required=0", n); end
        total++; if (stall !== 1'b0) begin bad++; $display("FAIL mflo_stall34 actual=%b required=0", stall); end
        total++; if (hilo_re !== 1'b1) begin bad++; $display("FAIL mflo_re34 actual=%b required=1", hilo_re); end
        total++; if (hilo_rdata !== e[31:0]) begin bad++; $display("FAIL mflo_data actual=%h required=%h", hilo_rdata, e[31:0]); end
        funct = F_MFHI;
        #1;
        total++; if (hilo_rdata !== e[63:32]) begin bad++; $display("FAIL mfhi_data actual=%h required=%h", hilo_rdata, e[63:32]); end
        tick();
        valid = 1'b0; ALUOp = 4'b0000; funct = 6'h00;
        tick();
    endtask

    task automatic test_flush();
        int nd;
        mt(F_MTHI, 32'hAAAA5555);
        mt(F_MTLO, 32'h12345678);
        issue(F_DIV, 32'd100, 32'd7);
        for (int k = 1; k <= 9; k++) tick();
        flush = 1'b1;
        valid = 1'b1; ALUOp = 4'b0010; funct = F_MULT; src_a = 32'h3; src_b = 32'h3;
        tick();
        void'(sb_q.pop_back());
        #1;
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL flush_busy11 actual=%b required=0", busy); end
        tick();
        flush = 1'b0; valid = 1'b0; ALUOp = 4'b0000; funct = 6'h00;
        #1;
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL flush_mult_accepted actual busy=%b required=0", busy); end
        nd = 0;
        for (int k = 0; k < 40; k++) begin
            if (done !== 1'b0) nd++;
            tick();
        end
        total++; if (nd != 0) begin bad++; $display("FAIL flush_done actual=%0d pulses required=0", nd); end
        total++; if (hi !== 32'hAAAA5555) begin bad++; $display("FAIL flush_hi actual=%h required=aaaa5555", hi); end
        total++; if (lo !== 32'h12345678) begin bad++; $display("FAIL flush_lo actual=%h required=12345678", lo); end
        issue(F_DIVU, 32'h9, 32'h0);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        void'(sb_q.pop_back());
        #1;
        total++; if (done !== 1'b0 || busy !== 1'b0) begin bad++; $display("FAIL finflush actual done=%b busy=%b required 0 0", done, busy); end
        total++; if (hi !== 32'hAAAA5555 || lo !== 32'h12345678) begin bad++; $display("FAIL finflush_hilo actual=%h_%h required=aaaa5555_12345678", hi, lo); end
        tick();
    endtask

    task automatic test_reset_mid();
        issue(F_MULT, 32'h7, 32'h9);
        for (int k = 1; k <= 19; k++) tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        void'(sb_q.pop_back());
        #1;
        total++; if (hi !== '0 || lo !== '0) begin bad++; $display("FAIL rstmid_hilo actual=%h_%h required=0_0", hi, lo); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL rstmid_busy actual=%b required=0", busy); end
        total++; if (done !== 1'b0) begin bad++; $display("FAIL rstmid_done actual=%b required=0", done); end
        mt(F_MTHI, 32'h1234);
        #1;
        total++; if (hi !== 32'h1234) begin bad++; $display("FAIL mthi actual=%h required=00001234", hi); end
        total++; if (lo !== 32'h0) begin bad++; $display("FAIL mthi_lo actual=%h required=0", lo); end
        tick();
    endtask

    initial begin
        rst_n = 1'b0; valid = 1'b0; flush = 1'b0;
        ALUOp = 4'b0000; funct = 6'h00; src_a = '0; src_b = '0;
        test_reset();
        test_decoder();
        test_mul();
        test_back_to_back();
        test_div();
        test_mflo_stall();
        test_flush();
        test_reset_mid();
        total++;
        if (sb_q.size() != 0) begin
            bad++;
            $display("FAIL sb_leftover actual=%0d required=0", sb_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
